bsg_vanilla_idiv_iterative: RTL and testbench
=============================================

BSG_VANILLA_IDIV_ITERATIVE -- requirements
Module: bsg_vanilla_idiv_iterative

Interface
REQ-001 SHALL have parameter width_p, default 32, operand/result width.
REQ-002 SHALL have parameter reg_addr_width_p, default 5, destination register tag width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port v_i  input  1  request valid.
REQ-006 SHALL have port ready_o  output  1  request accepted this cycle when v_i&ready_o.
REQ-007 SHALL have port op_i  input  2  idiv_op_e (eDIV, eDIVU, eREM, eREMU).
REQ-008 SHALL have port rs1_i  input  width_p  dividend.
REQ-009 SHALL have port rs2_i  input  width_p  divisor.
REQ-010 SHALL have port rd_i  input  reg_addr_width_p  writeback tag.
REQ-011 SHALL have port flush_i  input  1  abort in-flight operation.
REQ-012 SHALL have port v_o  output  1  result valid.
REQ-013 SHALL have port result_o  output  width_p  quotient or remainder.
REQ-014 SHALL have port rd_o  output  reg_addr_width_p  tag of result.
REQ-015 SHALL have port yumi_i  input  1  consumer takes result; legal only when v_o=1.

Function
REQ-016 SHALL implement FSM states eIDLE, eCALC, eDONE.
REQ-017 ready_o SHALL be 1 only in eIDLE and flush_i=0; v_o SHALL be 1 only in eDONE.
REQ-018 On v_i&ready_o SHALL latch op, rd, sign flags, and |rs1|, |rs2| (magnitudes for eDIV/eREM, raw for eDIVU/eREMU).
REQ-019 On accept with rs2_i==0 SHALL go to eDONE next cycle: DIV/DIVU result all-ones, REM/REMU result rs1_i unchanged.
REQ-020 Otherwise SHALL go to eCALC with step counter 0; each eCALC cycle performs one restoring shift-subtract step producing one quotient bit.
REQ-021 After width_p eCALC cycles (counter width_p-1) SHALL apply sign fixup and enter eDONE; v_o rises width_p+1 cycles after the accept edge.
REQ-022 Sign fixup: quotient negated iff signed op and operand signs differ; remainder negated iff signed op and dividend negative.
REQ-023 Signed overflow (rs1=most-negative, rs2=-1, eDIV) SHALL yield most-negative; eREM SHALL yield 0; no special path needed beyond REQ-022.
REQ-024 result_o/rd_o SHALL be held stable while v_o=1 and yumi_i=0.
REQ-025 On v_o&yumi_i SHALL return to eIDLE next cycle; new request accepted no earlier than that cycle.
REQ-026 flush_i=1 in any state SHALL force eIDLE next cycle, discard result, and suppress ready_o that cycle; flush_i has priority over yumi_i and v_i.
REQ-027 result_o SHALL be 0 whenever v_o=0.

Reset
REQ-028 reset_n_i low SHALL immediately force eIDLE, counter 0, v_o=0, result_o=0, rd_o=0; ready_o=1 after deassertion.
REQ-029 Reset mid-eCALC SHALL drop the operation with no result produced.

Structure
REQ-030 idiv_op_e SHALL come from the shared vanilla package; FSM state enum SHALL be local to the module.
REQ-031 No sub-module; counter and remainder/quotient shift registers SHALL be inline, single width_p-bit subtractor.

Verification
REQ-032 eDIVU 100/7 -> v_o at accept+33, result_o=14; eREMU same -> 2.
REQ-033 eDIV -7/2 -> 0xFFFFFFFD (-3); eREM -7/2 -> 0xFFFFFFFF (-1).
REQ-034 eDIV 5/0 -> v_o at accept+1, 0xFFFFFFFF; eREM 5/0 -> 5.
REQ-035 eDIV 0x80000000/0xFFFFFFFF -> 0x80000000; eREM same -> 0.
REQ-036 flush_i at accept+10 -> eIDLE next cycle, no v_o; next request 9/3 eDIVU -> 3 with correct rd_o.
REQ-037 yumi_i held low 5 cycles in eDONE -> result_o/rd_o stable, ready_o=0; reset_n_i pulse mid-eCALC -> v_o=0, ready_o=1 after release.

Source files
------------

// File: rtl/bsg_vanilla_idiv_iterative_pkg.sv
// Shared vanilla-core types used by the iterative integer divider.
package bsg_vanilla_idiv_iterative_pkg;

  typedef enum logic [1:0] {
    eDIV  = 2'd0,
    eDIVU = 2'd1,
    eREM  = 2'd2,
    eREMU = 2'd3
  } idiv_op_e;

endpackage

// File: rtl/bsg_vanilla_idiv_iterative.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fixup on the final step, result held until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where v_i && ready_o; a result
// transfers on a rising edge where v_o && yumi_i. flush_i overrides both.
module bsg_vanilla_idiv_iterative
  import bsg_vanilla_idiv_iterative_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  idiv_op_e                    op_i,
  input  logic [width_p-1:0]          rs1_i,
  input  logic [width_p-1:0]          rs2_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  input  logic                        flush_i,
  output logic                        v_o,
  output logic [width_p-1:0]          result_o,
  output logic [reg_addr_width_p-1:0] rd_o,
  input  logic                        yumi_i
);

  localparam int cnt_w_lp = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_step_lp = cnt_w_lp'(width_p - 1);

  typedef enum logic [1:0] {eIDLE, eCALC, eDONE} state_e;

  state_e                      state_r, state_n;
  idiv_op_e                    op_r;
  logic [reg_addr_width_p-1:0] rd_r;
  logic                        neg_quo_r, neg_rem_r;
  logic [cnt_w_lp-1:0]         cnt_r;
  logic [width_p-1:0]          quo_r, rem_r, divisor_r, result_r;

  logic                        accept;
  logic                        in_signed, rs1_neg, rs2_neg;
  logic [width_p-1:0]          rs1_mag, rs2_mag;
  logic [width_p:0]            shifted, diff;
  logic                        fits;
  logic [width_p-1:0]          rem_next, quo_next, quo_fix, rem_fix;
  logic                        op_is_rem;

  assign ready_o = (state_r == eIDLE) && !flush_i;
  assign accept  = v_i && ready_o;
  assign v_o     = (state_r == eDONE);
  assign result_o = v_o ? result_r : '0;
  assign rd_o    = rd_r;

  assign in_signed = (op_i == eDIV) || (op_i == eREM);
  assign rs1_neg   = in_signed && rs1_i[width_p-1];
  assign rs2_neg   = in_signed && rs2_i[width_p-1];
  assign rs1_mag   = rs1_neg ? -rs1_i : rs1_i;
  assign rs2_mag   = rs2_neg ? -rs2_i : rs2_i;

  // Partial remainder is one bit wider than the divisor after the shift.
  assign shifted  = {rem_r, quo_r[width_p-1]};
  assign diff     = shifted - {1'b0, divisor_r};
  assign fits     = !diff[width_p];
  assign rem_next = fits ? diff[width_p-1:0] : shifted[width_p-1:0];
  assign quo_next = {quo_r[width_p-2:0], fits};

  assign quo_fix   = neg_quo_r ? -quo_next : quo_next;
  assign rem_fix   = neg_rem_r ? -rem_next : rem_next;
  assign op_is_rem = (op_r == eREM) || (op_r == eREMU);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eIDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    if (flush_i) begin
      state_n = eIDLE;
    end else begin
      case (state_r)
        eIDLE: if (v_i) state_n = (rs2_i == '0) ? eDONE : eCALC;
        eCALC: if (cnt_r == last_step_lp) state_n = eDONE;
        eDONE: if (yumi_i) state_n = eIDLE;
        default: state_n = eIDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_r      <= eDIV;
      rd_r      <= '0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      divisor_r <= '0;
      result_r  <= '0;
    end else if (accept) begin
      op_r      <= op_i;
      rd_r      <= rd_i;
      neg_quo_r <= rs1_neg ^ rs2_neg;
      neg_rem_r <= rs1_neg;
      cnt_r     <= '0;
      quo_r     <= rs1_mag;
      rem_r     <= '0;
      divisor_r <= rs2_mag;
      // Divide-by-zero result is settled here; the CALC path never runs.
      result_r  <= ((op_i == eDIV) || (op_i == eDIVU)) ? '1 : rs1_i;
    end else if (state_r == eCALC) begin
      quo_r <= quo_next;
      rem_r <= rem_next;
      cnt_r <= cnt_r + cnt_w_lp'(1);
      if (cnt_r == last_step_lp) result_r <= op_is_rem ? rem_fix : quo_fix;
    end
  end

endmodule

// File: tb/tb_bsg_vanilla_idiv_iterative.sv
// Randomized and directed checks of the iterative divider against an arithmetic model.
module tb_bsg_vanilla_idiv_iterative;
  import bsg_vanilla_idiv_iterative_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_o;
  idiv_op_e    op_i = eDIV;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        v_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        yumi_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  rd_q[$];

  bsg_vanilla_idiv_iterative #(.width_p(32), .reg_addr_width_p(5)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .v_o(v_o), .result_o(result_o), .rd_o(rd_o), .yumi_i(yumi_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic
  function automatic logic [31:0] ref_div(input idiv_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return ((op == eDIV) || (op == eDIVU)) ? 32'hFFFF_FFFF : a;
    case (op)
      eDIV:    return 32'(sa / sb);
      eREM:    return 32'(sa % sb);
      eDIVU:   return a / b;
      default: return a % b;
    endcase
  endfunction

  // driver: issue one request, check latency, result, hold stability and release
  task automatic run_op(input idiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    int cyc;
    logic [31:0] exp_r;
    logic [4:0]  exp_rd;
    exp_q.push_back(ref_div(op, a, b));
    rd_q.push_back(rd);
    @(negedge clk_i);
    cyc = 0;
    while (!ready_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    check("ready_before_req", ready_o, 1);
    v_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    @(posedge clk_i);
    #1;
    v_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
      if (!v_o) check("result_zero_while_busy", result_o, 0);
    end while (!v_o && cyc < 100);
    check("latency", cyc, (b == 32'd0) ? 1 : 33);
    exp_r  = exp_q.pop_front();
    exp_rd = rd_q.pop_front();
    check("result", result_o, exp_r);
    check("rd", rd_o, exp_rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_v", v_o, 1);
      check("hold_result", result_o, exp_r);
      check("hold_rd", rd_o, exp_rd);
      check("hold_ready", ready_o, 0);
    end
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_yumi", ready_o, 1);
    check("v_after_yumi", v_o, 0);
  endtask

  task automatic start_only(input idiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    check("ready_before_start", ready_o, 1);
    v_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = 5'd9;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (v_o) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    idiv_op_e    op;
    #1;
    check("reset_v", v_o, 0);
    check("reset_result", result_o, 0);
    check("reset_rd", rd_o, 0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", ready_o, 1);

    // directed values
    run_op(eDIVU, 32'd100, 32'd7, 5'd1, 0);
    run_op(eREMU, 32'd100, 32'd7, 5'd2, 1);
    run_op(eDIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    run_op(eREM, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(eDIV, 32'd5, 32'd0, 5'd5, 0);
    run_op(eREM, 32'd5, 32'd0, 5'd6, 0);
    run_op(eDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(eREM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(eDIVU, 32'hFFFF_FFFF, 32'd1, 5'd10, 0);
    run_op(eREMU, 32'd3, 32'hFFFF_FFFF, 5'd11, 0);

    // flush ten cycles after accept
    start_only(eDIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush_blocks_ready", ready_o, 0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("idle_after_flush", ready_o, 1);
    expect_silence("no_result_after_flush", 40);
    run_op(eDIVU, 32'd9, 32'd3, 5'd17, 2);

    // long hold with yumi low
    run_op(eDIV, 32'd123456, 32'hFFFF_FFF0, 5'd21, 5);

    // reset mid-calculation
    start_only(eDIV, 32'd77, 32'd5);
    repeat (5) @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    check("midreset_v", v_o, 0);
    check("midreset_result", result_o, 0);
    check("midreset_rd", rd_o, 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_midreset", ready_o, 1);
    expect_silence("no_result_after_reset", 40);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = idiv_op_e'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
